// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between instruction fetch (port 0)
// and data load/store (port 1); one transaction in flight, fixed IDLE/ISSUE/RESP sequence.
module ram_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              gnt0_o,
    output logic              done0_o,
    output logic              err0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt1_o,
    output logic              done1_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              ram_load_o,
    output logic              ram_save_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              win1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    // Port 1 wins when alone, or under contention when port 0 was served last.
    assign win1      = req1_i & (~req0_i | ~last_q);
    assign sel_we    = win1 ? we1_i    : we0_i;
    assign sel_addr  = win1 ? addr1_i  : addr0_i;
    assign sel_wdata = win1 ? wdata1_i : wdata0_i;
    assign sel_bad   = 64'(sel_addr) >= 64'(MEM_WORDS);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        bad_d   = bad_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req0_i | req1_i) begin
                    state_d = StIssue;
                    owner_d = win1;
                    last_d  = win1;
                    we_d    = sel_we;
                    bad_d   = sel_bad;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    logic issue, resp, rd_ok;

    assign issue = (state_q == StIssue);
    assign resp  = (state_q == StResp);
    assign rd_ok = resp & ~we_q & ~bad_q;

    assign gnt0_o  = issue & ~owner_q;
    assign gnt1_o  = issue & owner_q;
    assign done0_o = resp & ~owner_q;
    assign done1_o = resp & owner_q;
    assign err0_o  = resp & ~owner_q & bad_q;
    assign err1_o  = resp & owner_q & bad_q;

    // Read data is the only output with a path from an input.
    assign rdata0_o = (rd_ok & ~owner_q) ? ram_rdata_i : '0;
    assign rdata1_o = (rd_ok & owner_q) ? ram_rdata_i : '0;

    assign ram_load_o  = issue & ~we_q & ~bad_q;
    assign ram_save_o  = issue & we_q & ~bad_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign busy_o      = issue | resp;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table of single transactions plus hand-written
// sequences for contention, asynchronous reset and request timing.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic [31:0] rdata0, rdata1;
    logic        ram_load, ram_save, busy;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_i     (req0),
        .we0_i      (we0),
        .addr0_i    (addr0),
        .wdata0_i   (wdata0),
        .gnt0_o     (gnt0),
        .done0_o    (done0),
        .err0_o     (err0),
        .rdata0_o   (rdata0),
        .req1_i     (req1),
        .we1_i      (we1),
        .addr1_i    (addr1),
        .wdata1_i   (wdata1),
        .gnt1_o     (gnt1),
        .done1_o    (done1),
        .err1_o     (err1),
        .rdata1_o   (rdata1),
        .ram_load_o (ram_load),
        .ram_save_o (ram_save),
        .ram_addr_o (ram_addr),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata),
        .busy_o     (busy)
    );

    // RAM model with registered read
    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) begin
        if (ram_save) mem[ram_addr] = ram_wdata;
        if (ram_load) ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        exp_port;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input int i);
        logic        wwe;
        logic [31:0] wad, wd;
        logic [1:0]  one_hot;
        vec_t v;
        v = vecs[i];
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        wwe     = v.exp_port ? v.w1 : v.w0;
        wad     = v.exp_port ? v.a1 : v.a0;
        wd      = v.exp_port ? v.d1 : v.d0;
        one_hot = v.exp_port ? 2'b10 : 2'b01;
        @(negedge clk);
        check($sformatf("v%0d gnt", i), 64'({gnt1, gnt0}), 64'(one_hot));
        check($sformatf("v%0d strobes/busy", i), 64'({ram_load, ram_save, busy}),
              64'({~wwe & ~v.exp_err, wwe & ~v.exp_err, 1'b1}));
        check($sformatf("v%0d ram_addr", i), 64'(ram_addr), 64'(wad));
        if (wwe && !v.exp_err) check($sformatf("v%0d ram_wdata", i), 64'(ram_wdata), 64'(wd));
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 32'hFFFF_FFFF; addr1 = 32'hFFFF_FFFF;
        @(negedge clk);
        check($sformatf("v%0d done", i), 64'({done1, done0, gnt1, gnt0, ram_load, ram_save}),
              64'({one_hot, 4'b0000}));
        check($sformatf("v%0d err", i), 64'({err1, err0}), v.exp_err ? 64'(one_hot) : 64'(0));
        check($sformatf("v%0d rdata", i), {rdata1, rdata0},
              v.exp_port ? {v.exp_rdata, 32'h0} : {32'h0, v.exp_rdata});
        @(negedge clk);
        check($sformatf("v%0d idle", i), 64'({busy, done0, done1}), 64'(0));
    endtask

    int gnt_port[$];
    int gnt_cyc[$];
    int both_cnt;
    int late_gnt;

    initial begin
        // r0 r1 w0 w1 a0 a1 d0 d1 port err rdata; last=1 out of reset
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 32'h5, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 32'h5};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 32'h5};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h100000, 32'h0, 32'h77, 1'b1, 1'b1, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0, 32'h12345678};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D};

        mem[32'h10]    = 32'hDEADBEEF;
        mem[32'hFFFFF] = 32'hCAFEF00D;

        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        repeat (2) @(negedge clk);
        check("reset ctrl", 64'({gnt0, gnt1, done0, done1, err0, err1, ram_load, ram_save, busy}),
              64'(0));
        check("reset ram_addr/wdata", {ram_addr, ram_wdata}, 64'(0));
        check("reset rdata", {rdata1, rdata0}, 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);
        check("bad addr not written", 64'(mem.exists(32'h100000)), 64'(0));

        // Continuous contention from reset release
        rst_n = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        rst_n = 1'b1;
        both_cnt = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both_cnt++;
            if (gnt0) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
            if (gnt1) begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr no dual grant", 64'(both_cnt), 64'(0));
        check("rr grant count", 64'(gnt_port.size()), 64'(4));
        for (int k = 0; k < 4 && k < gnt_port.size(); k++) begin
            check($sformatf("rr grant %0d port", k), 64'(gnt_port[k]), 64'(k % 2));
            check($sformatf("rr grant %0d cycle", k), 64'(gnt_cyc[k]), 64'(1 + 3 * k));
        end

        // Asynchronous reset during a write ISSUE
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hAA;
        @(negedge clk);
        check("pre-reset save/gnt", 64'({ram_save, gnt0}), 64'(2'b11));
        #1 rst_n = 1'b0;
        #1 check("async reset drops", 64'({ram_save, gnt0, busy}), 64'(0));
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset write suppressed", 64'(mem.exists(32'h30)), 64'(0));
        req0 = 1'b1; addr0 = 32'h10;
        req1 = 1'b1; addr1 = 32'h20;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset first grant", 64'({gnt1, gnt0}), 64'(2'b01));
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Request rising during RESP waits for IDLE
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        check("resp done0", 64'(done0), 64'(1));
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        @(negedge clk);
        check("late req idle", 64'(gnt1), 64'(0));
        @(negedge clk);
        check("late req granted", 64'(gnt1), 64'(1));
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        // One-cycle pulse while busy is never granted
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        late_gnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (gnt1) late_gnt++;
        end
        check("pulse req ignored", 64'(late_gnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
